// File: rtl/da9708_burst_seq_if.sv
// da9708_burst_seq_if: burst configuration handshake, abort/status and DAC data bus
interface da9708_burst_seq_if #(
  parameter int PHASE_W = 32,
  parameter int CNT_W = 16
);
  logic cfg_valid;
  logic cfg_ready;
  logic [1:0] cfg_wave;
  logic [PHASE_W-1:0] cfg_step;
  logic [7:0] cfg_amp;
  logic [CNT_W-1:0] cfg_cycles;
  logic abort;
  logic busy;
  logic done;
  logic [7:0] da9708_data;
  modport master (
    output cfg_valid, cfg_wave, cfg_step, cfg_amp, cfg_cycles, abort,
    input cfg_ready, busy, done, da9708_data
  );
  modport slave (
    input cfg_valid, cfg_wave, cfg_step, cfg_amp, cfg_cycles, abort,
    output cfg_ready, busy, done, da9708_data
  );
endinterface

// File: rtl/da9708_burst_seq.sv
// da9708_burst_seq: phase-accumulator waveform burst generator for the DA9708 DAC bus
module da9708_burst_seq #(
  parameter int CLK_FRE = 50,
  parameter int PHASE_W = 32,
  parameter int CNT_W = 16,
  parameter logic [7:0] IDLE_CODE = 8'd128
) (
  input logic clk,
  input logic rst,
  da9708_burst_seq_if.slave bus
);
  if (PHASE_W < 8) begin : g_phase_chk
    $error("PHASE_W must be at least 8");
  end
  if (CLK_FRE <= 0) begin : g_clk_chk
    $error("CLK_FRE must be positive");
  end
  typedef enum logic [1:0] {IDLE, RUN, PARK} state_t;
  state_t state;
  logic [PHASE_W-1:0] phase, step;
  logic [CNT_W-1:0] cnt, cycles;
  logic [1:0] wave;
  logic [7:0] amp, p, raw, code, data;
  logic [PHASE_W:0] nxt;
  logic signed [8:0] s;
  logic signed [17:0] prod;
  logic wrap_end, done;
  // waveform lookup from the top phase byte, then signed scaling around mid-scale
  always_comb begin
    p = phase[PHASE_W-1 -: 8];
    raw = wave == 2'd0 ? {8{p[7]}} :
          wave == 2'd1 ? p :
          wave == 2'd2 ? ~p :
          p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
    s = $signed({1'b0, raw}) - 9'sd128;
    prod = s * $signed({1'b0, amp});
    code = 8'(prod >>> 8) + 8'd128;
    nxt = {1'b0, phase} + {1'b0, step};
    wrap_end = nxt[PHASE_W] && cycles != '0 && CNT_W'(cnt + 1'b1) == cycles;
  end
  // sequencer: accept config, run the accumulator, park at mid-scale with a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      cnt <= '0;
      wave <= '0;
      step <= '0;
      amp <= '0;
      cycles <= '0;
      data <= IDLE_CODE;
      done <= 1'b0;
    end else begin
      done <= state == PARK;
      if (state == IDLE) begin
        if (bus.cfg_valid) begin
          wave <= bus.cfg_wave;
          step <= bus.cfg_step;
          amp <= bus.cfg_amp;
          cycles <= bus.cfg_cycles;
          phase <= '0;
          cnt <= '0;
          state <= RUN;
        end
      end else if (state == RUN) begin
        data <= code;
        phase <= nxt[PHASE_W-1:0];
        if (nxt[PHASE_W]) cnt <= cnt + 1'b1;
        state <= (bus.abort || wrap_end) ? PARK : RUN;
      end else begin
        data <= IDLE_CODE;
        state <= IDLE;
      end
    end
  end
  assign bus.cfg_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.done = done;
  assign bus.da9708_data = data;
endmodule

// File: tb/tb_da9708_burst_seq.sv
// tb_da9708_burst_seq: scoreboard bench for the burst sequencer with a sample-level reference model
module tb_da9708_burst_seq;
  logic clk = 1'b0;
  logic rst;
  da9708_burst_seq_if bus();
  da9708_burst_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // expected {cfg_ready, busy, done, data} for every clock the block is active
  logic [10:0] q[$];
  logic [10:0] mon_e;
  int total = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] ex);
    total++;
    if (act !== ex) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
    end
  endtask

  // DAC code for top phase byte p: waveform shape, then floor-scaled around 128
  function automatic logic [7:0] fref(input logic [1:0] w, input int p, input int a);
    int raw, x;
    raw = w == 0 ? (p >= 128 ? 255 : 0) : w == 1 ? p : w == 2 ? 255 - p :
          (p < 128 ? 2 * p : 511 - 2 * p);
    x = (raw - 128) * a;
    return 8'(x >= 0 ? 128 + x / 256 : 128 - (-x + 255) / 256);
  endfunction

  // sample n uses phase (n-1)*step; the burst ends on the sample whose step
  // completes the cycles-th period, or on the abort sample; returns sample count
  function automatic int push_model(input logic [1:0] w, input logic [31:0] st,
                                    input logic [7:0] a, input logic [15:0] cy, input int ab);
    int n;
    logic [63:0] ph, wr;
    q.push_back({1'b0, 1'b1, 1'b0, 8'd128});
    n = 0;
    do begin
      n++;
      ph = 64'(n - 1) * 64'(st);
      wr = (64'(n) * 64'(st)) >> 32;
      q.push_back({1'b0, 1'b1, 1'b0, fref(w, int'(ph[31:24]), int'(a))});
    end while (!(n == ab || (cy != 0 && wr == 64'(cy))) && n < 100000);
    q.push_back({1'b1, 1'b0, 1'b1, 8'd128});
    return n;
  endfunction

  always @(negedge clk) begin
    if (rst !== 1'b1 && (bus.busy || bus.done)) begin
      if (q.size() == 0) begin
        total++;
        fails++;
        $display("FAIL unexpected_output: got busy=%b done=%b data=%0d, required idle", bus.busy, bus.done, bus.da9708_data);
      end else begin
        mon_e = q.pop_front();
        check("sample", 32'({bus.cfg_ready, bus.busy, bus.done, bus.da9708_data}), 32'(mon_e));
      end
    end
  end

  task automatic start_cfg(input logic [1:0] w, input logic [31:0] st, input logic [7:0] a,
                           input logic [15:0] cy, input int ab, input bit hold, output int n);
    int g;
    g = 0;
    while (!bus.cfg_ready && g < 5000) begin
      @(negedge clk);
      g++;
    end
    bus.cfg_wave = w;
    bus.cfg_step = st;
    bus.cfg_amp = a;
    bus.cfg_cycles = cy;
    bus.cfg_valid = 1'b1;
    n = push_model(w, st, a, cy, ab);
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      bus.cfg_wave = 2'($urandom);
      bus.cfg_step = $urandom;
      bus.cfg_amp = 8'($urandom);
      bus.cfg_cycles = 16'($urandom);
    end else bus.cfg_valid = 1'b0;
  endtask

  // abort, if requested, is held high for exactly the ab-th edge after acceptance
  task automatic wait_done(input int ab, output int lat);
    int k;
    k = 0;
    bus.abort = ab == 1;
    while (!bus.done && k < 5000) begin
      @(negedge clk);
      k++;
      bus.abort = ab == k + 1;
    end
    bus.abort = 1'b0;
    if (!bus.done) begin
      total++;
      fails++;
      $display("FAIL done_timeout: no done within %0d clocks", k);
      q.delete();
    end
    lat = k;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, ab;
    logic [15:0] cy;
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_wave = '0;
    bus.cfg_step = '0;
    bus.cfg_amp = '0;
    bus.cfg_cycles = '0;
    bus.abort = 1'b0;
    #1;
    check("rst_data", 32'(bus.da9708_data), 32'd128);
    check("rst_ready", 32'(bus.cfg_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    start_cfg(2'd0, 32'h8000_0000, 8'd255, 16'd3, 0, 1'b0, n);
    wait_done(0, lat);
    check("square_latency", 32'(lat), 32'd7);

    start_cfg(2'd1, 32'h0100_0000, 8'd255, 16'd1, 0, 1'b0, n);
    wait_done(0, lat);
    check("sawup_latency", 32'(lat), 32'd257);

    start_cfg(2'd3, 32'h1000_0000, 8'd0, 16'd2, 0, 1'b0, n);
    wait_done(0, lat);
    check("tri_amp0_latency", 32'(lat), 32'd33);

    start_cfg(2'd0, 32'h8000_0000, 8'd200, 16'd0, 11, 1'b1, n);
    wait_done(11, lat);
    check("abort_latency", 32'(lat), 32'd12);
    start_cfg(2'd1, 32'h0400_0000, 8'd255, 16'd1, 0, 1'b0, n);
    wait_done(0, lat);
    check("after_abort_latency", 32'(lat), 32'(n + 1));

    for (int i = 0; i < 12; i++) begin
      cy = 16'($urandom_range(0, 3));
      ab = cy == 0 ? int'($urandom_range(1, 40)) :
           ($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 100)) : 0);
      start_cfg(2'($urandom), $urandom | 32'h0200_0000, 8'($urandom), cy, ab, 1'b0, n);
      wait_done(ab, lat);
      check("rand_latency", 32'(lat), 32'(n + 1));
    end

    start_cfg(2'd3, 32'h0200_0000, 8'd180, 16'd3, 0, 1'b0, n);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_data", 32'(bus.da9708_data), 32'd128);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_ready", 32'(bus.cfg_ready), 32'd1);
    check("async_rst_done", 32'(bus.done), 32'd0);
    q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(bus.done), 32'd0);
    end
    start_cfg(2'd2, 32'h0800_0000, 8'd99, 16'd2, 0, 1'b0, n);
    wait_done(0, lat);
    check("post_rst_latency", 32'(lat), 32'(n + 1));

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
